// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, two prioritised write ports,
// optional write-to-read bypass and a per-register pending bit for RAW hazard stalls.
module regfile_scoreboard #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter int unsigned     AW       = 5,
    parameter int unsigned     SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_RESET = 32'h000383FC,
    parameter bit              BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr0,
    input  logic [AW-1:0]   rd_addr1,
    output logic [XLEN-1:0] rd_data0,
    output logic [XLEN-1:0] rd_data1,
    output logic            rd_busy0,
    output logic            rd_busy1,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_data,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            flush,
    output logic [AW:0]     pend_count
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [CW-1:0]   pend_count_q, pend_count_d;

    logic wr0_act, wr1_act, iss_act;
    logic hit00, hit01, hit10, hit11;

    assign wr0_act = wr0_en && (wr0_addr != '0);
    assign wr1_act = wr1_en && (wr1_addr != '0);
    assign iss_act = issue_en && (issue_addr != '0);

    // hitNK: write port N targets read port K this cycle (only meaningful with bypass)
    assign hit00 = BYPASS && wr0_act && (wr0_addr == rd_addr0);
    assign hit10 = BYPASS && wr1_act && (wr1_addr == rd_addr0);
    assign hit01 = BYPASS && wr0_act && (wr0_addr == rd_addr1);
    assign hit11 = BYPASS && wr1_act && (wr1_addr == rd_addr1);

    always_comb begin
        rd_data0 = mem[rd_addr0];
        if (rd_addr0 == '0) begin
            rd_data0 = '0;
        end else if (hit10) begin
            rd_data0 = wr1_data;
        end else if (hit00) begin
            rd_data0 = wr0_data;
        end
    end

    always_comb begin
        rd_data1 = mem[rd_addr1];
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (hit11) begin
            rd_data1 = wr1_data;
        end else if (hit01) begin
            rd_data1 = wr0_data;
        end
    end

    assign rd_busy0 = (rd_addr0 != '0) && pend_q[rd_addr0] && !(hit00 || hit10);
    assign rd_busy1 = (rd_addr1 != '0) && pend_q[rd_addr1] && !(hit01 || hit11);

    // Issue is applied after the write clears so a new producer keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (wr0_act) begin
                pend_d[wr0_addr] = 1'b0;
            end
            if (wr1_act) begin
                pend_d[wr1_addr] = 1'b0;
            end
            if (iss_act) begin
                pend_d[issue_addr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        pend_count_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            pend_count_d = pend_count_d + CW'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q       <= '0;
            pend_count_q <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            if (wr0_act) begin
                mem[wr0_addr] <= wr0_data;
            end
            if (wr1_act) begin
                mem[wr1_addr] <= wr1_data;
            end
        end
    end

    assign pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed vectors push expected read-port and
// pend_count values; a negedge monitor pops and compares them.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_busy0, rd_busy1;
    logic        wr0_en, wr1_en;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [5:0]  pend_count;

    typedef struct packed {
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
        logic [5:0]  pc;
    } exp_t;

    exp_t exp_q [$];
    int   id_q  [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    localparam logic [31:0] SP = 32'h000383FC;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .rd_busy0   (rd_busy0),
        .rd_busy1   (rd_busy1),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .pend_count (pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: read outputs are presented every cycle; sample on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = '{d0: rd_data0, b0: rd_busy0, d1: rd_data1, b1: rd_busy1, pc: pend_count};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got d0=%h b0=%b d1=%h b1=%b pc=%0d, required d0=%h b0=%b d1=%h b1=%b pc=%0d",
                         id, a.d0, a.b0, a.d1, a.b1, a.pc, e.d0, e.b0, e.d1, e.b1, e.pc);
            end
        end
    end

    task automatic expect_out(input logic [31:0] d0, input logic b0,
                              input logic [31:0] d1, input logic b1, input logic [5:0] pc);
        exp_q.push_back('{d0: d0, b0: b0, d1: d1, b1: b1, pc: pc});
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    // Advance to just after the next rising edge, then drive one cycle of inputs.
    task automatic cyc(input logic [4:0] r0, input logic [4:0] r1,
                       input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic ie, input logic [4:0] ia, input logic fl);
        @(posedge clk);
        #1;
        rd_addr0 = r0; rd_addr1 = r1;
        wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
        wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
        issue_en = ie; issue_addr = ia; flush = fl;
    endtask

    task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
        cyc(r0, r1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        rd_addr0 = 5'd2; rd_addr1 = 5'd5;
        idle_inputs();
        #1;
        expect_out(SP, 0, 0, 0, 0);         // contents visible while held in reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset release contents
        rd(2, 5);            expect_out(SP, 0, 0, 0, 0);
        rd(0, 5);            expect_out(0, 0, 0, 0, 0);

        // Same-address double write: port 1 wins, bypass too
        cyc(5, 5, 1, 5, 32'hAAAA, 1, 5, 32'h5555, 0, 0, 0);
        expect_out(32'h5555, 0, 32'h5555, 0, 0);
        rd(5, 2);            expect_out(32'h5555, 0, SP, 0, 0);

        // x0 write and issue ignored
        cyc(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0);
        expect_out(0, 0, 0, 0, 0);
        rd(0, 0);            expect_out(0, 0, 0, 0, 0);

        // Issue x7, then load writeback clears it with bypass
        cyc(7, 7, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        expect_out(0, 0, 0, 0, 0);
        rd(7, 5);            expect_out(0, 1, 32'h5555, 0, 1);
        cyc(7, 7, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 0);
        expect_out(32'h1234, 0, 32'h1234, 0, 1);
        rd(7, 0);            expect_out(32'h1234, 0, 0, 0, 0);

        // Issue beats same-cycle write; data still written
        cyc(9, 0, 1, 9, 32'h42, 0, 0, 0, 1, 9, 0);
        expect_out(32'h42, 0, 0, 0, 0);
        rd(9, 9);            expect_out(32'h42, 1, 32'h42, 1, 1);
        cyc(3, 4, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        expect_out(0, 0, 0, 0, 1);
        cyc(3, 4, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        expect_out(0, 1, 0, 0, 2);
        cyc(4, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        expect_out(0, 1, 32'h42, 1, 3);
        // Flush drops the same-cycle issue
        cyc(6, 3, 0, 0, 0, 0, 0, 0, 1, 6, 1);
        expect_out(0, 0, 0, 1, 3);
        rd(6, 9);            expect_out(0, 0, 32'h42, 0, 0);

        // Writes to distinct addresses both commit
        cyc(10, 11, 1, 10, 32'h10, 1, 11, 32'h11, 0, 0, 0);
        expect_out(32'h10, 0, 32'h11, 0, 0);
        rd(10, 11);          expect_out(32'h10, 0, 32'h11, 0, 0);

        // Top register index, and overwrite SP
        cyc(31, 2, 1, 2, 32'hCAFE, 0, 0, 0, 1, 31, 0);
        expect_out(0, 0, 32'hCAFE, 0, 0);
        rd(31, 2);           expect_out(0, 1, 32'hCAFE, 0, 1);

        // Issue x8 then async reset mid-cycle
        cyc(8, 2, 0, 0, 0, 0, 0, 0, 1, 8, 0);
        expect_out(0, 0, 32'hCAFE, 0, 1);
        rd(8, 31);           expect_out(0, 1, 0, 1, 2);
        rd(8, 2);
        #2 rst = 1'b0;
        #1 expect_out(0, 0, SP, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        rd(31, 7);           expect_out(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
